// File: rtl/riscv_pkg.sv
// Shared fetch-side constants and types.
// Imported by the fetch stage and its next-PC generator.
package riscv_pkg;

  localparam int INST_WIDTH = 32;
  localparam int PC_WIDTH   = 15;
  localparam int PC_INCR    = 4;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_TRAP = 2'd2
  } fetch_state_e;

  function automatic logic
    pc_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/riscv_ifetch_pcgen.sv
// Next-PC selection (hold / +4 / redirect) and
// redirect-target alignment check.
module riscv_ifetch_pcgen #(
  parameter int PC_WIDTH = riscv_pkg::PC_WIDTH
) (
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                redir_i,
  input  logic [PC_WIDTH-1:0] redir_pc_i,
  input  logic                advance_i,
  output logic [PC_WIDTH-1:0] next_pc_o,
  output logic                misalign_o
);

  import riscv_pkg::*;

  logic take_redir;
  logic [PC_WIDTH-1:0] pc_inc;

  assign misalign_o = pc_misaligned(redir_pc_i[1:0]);
  assign take_redir = redir_i & ~misalign_o;
  // Wraps modulo 2^PC_WIDTH by construction.
  assign pc_inc = pc_i + PC_WIDTH'(PC_INCR);

  always_comb begin
    next_pc_o = pc_i;
    unique case (1'b1)
      take_redir: next_pc_o = redir_pc_i;
      advance_i:  next_pc_o = pc_inc;
      default:    next_pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction fetch stage: owns the PC, drives imem,
// and holds the IF/ID register with valid/ready toward decode.
module riscv_ifetch #(
  parameter int INST_WIDTH = riscv_pkg::INST_WIDTH,
  parameter int PC_WIDTH   = riscv_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   imem_pc,
  input  logic [INST_WIDTH-1:0] imem_inst,
  input  logic                  redir_valid,
  input  logic [PC_WIDTH-1:0]   redir_pc,
  input  logic                  id_ready,
  output logic                  if_valid,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic                  trap,
  output logic [PC_WIDTH-1:0]   trap_pc
);

  import riscv_pkg::*;

  localparam logic BOOT_MISALIGN =
    pc_misaligned(RESET_PC[1:0]);

  fetch_state_e          state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   pc_d;
  logic [PC_WIDTH-1:0]   if_pc_q;
  logic [PC_WIDTH-1:0]   trap_pc_q;
  logic [INST_WIDTH-1:0] if_inst_q;
  logic                  if_valid_q;
  logic                  trap_q;

  logic in_run;
  logic redir;
  logic advance;
  logic misalign;

  assign in_run  = (state_q == FETCH_RUN);
  assign redir   = in_run & redir_valid;
  // Redirect beats both capture and stall.
  assign advance = in_run & ~redir_valid &
                   (~if_valid_q | id_ready);

  riscv_ifetch_pcgen #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pcgen (
    .pc_i      (pc_q),
    .redir_i   (redir),
    .redir_pc_i(redir_pc),
    .advance_i (advance),
    .next_pc_o (pc_d),
    .misalign_o(misalign)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH_BOOT;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
      trap_q     <= 1'b0;
      trap_pc_q  <= '0;
    end else begin
      unique case (state_q)
        FETCH_BOOT: begin
          if (BOOT_MISALIGN) begin
            state_q   <= FETCH_TRAP;
            trap_q    <= 1'b1;
            trap_pc_q <= RESET_PC;
          end else begin
            state_q <= FETCH_RUN;
          end
        end
        FETCH_RUN: begin
          pc_q <= pc_d;
          if (redir && misalign) begin
            state_q    <= FETCH_TRAP;
            trap_q     <= 1'b1;
            trap_pc_q  <= redir_pc;
            if_valid_q <= 1'b0;
          end else if (redir) begin
            if_valid_q <= 1'b0;
          end else if (advance) begin
            if_inst_q  <= imem_inst;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
          end
        end
        FETCH_TRAP: begin
          if_valid_q <= 1'b0;
        end
        default: begin
          state_q    <= FETCH_TRAP;
          trap_q     <= 1'b1;
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_pc  = pc_q;
  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign if_pc    = if_pc_q;
  assign trap     = trap_q;
  assign trap_pc  = trap_pc_q;

endmodule
